pipe_stage_hs: RTL and testbench

Parametrised pipeline stage register, successor to the fixed-field inter-stage registers (IF/ID … MEM/WB). It carries an arbitrary payload and a kill-able control field, and uses a valid/ready handshake in place of a single enable. An optional 2-entry skid buffer gives full throughput with registered ready. It adds synchronous flush with bubble insertion and a sticky halt that blocks further intake once a halt beat enters.

---
 rtl/pipe_stage_hs.sv | 206 ++++++++++++++++++++
 tb/tb_pipe_stage_hs.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// ----------------------------------------------------------------------------
// pipe_stage_hs
//
// Generic inter-stage pipeline register with a valid/ready handshake. It
// carries an opaque payload plus a control field that is zeroed whenever
// no valid beat is present. A synchronous flush kills all held beats and
// any beat offered in the same cycle. A halt marker in the control field
// makes the stage stop accepting new beats until flush or reset.
//
// With SKID=1 a second (skid) register absorbs the one beat that can arrive
// after downstream stalls. This lets in_ready come straight from flops and
// still sustain one beat per cycle. With SKID=0 there is a single register
// and in_ready depends combinationally on out_ready.
//
// Parameters:
//   DATA_W   payload width
//   CTRL_W   control-field width (zeroed on bubbles and flushes)
//   SKID     1 = 2-entry skid buffer, 0 = single register
//   HALT_BIT index of the halt marker inside the control field
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   flush      synchronous kill of all held and incoming beats
//   in_valid   upstream beat present
//   in_ready   stage can accept a beat (held 0 while in reset)
//   in_ctrl    upstream control field
//   in_data    upstream payload
//   out_valid  beat present toward downstream
//   out_ready  downstream accepts
//   out_ctrl   control field, 0 when out_valid=0
//   out_data   payload
//   occupancy  number of held beats (0..2), registered
//   halted     sticky flag: a halt beat has been accepted
// ----------------------------------------------------------------------------
module pipe_stage_hs #(
    parameter int DATA_W   = 64,
    parameter int CTRL_W   = 4,
    parameter int SKID     = 1,
    parameter int HALT_BIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic              halted
);

    // Main register: the beat currently presented downstream.
    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;

    // Skid register: the second beat, only ever valid while main is full.
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    // Next-state values.
    logic              main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_d;
    logic              skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_d;
    logic              halted_d;
    logic [1:0]        occupancy_d;

    logic accept;
    logic emit;

    // ------------------------------------------------------------------------
    // Ready generation. Both variants are gated by rst so that upstream sees
    // in_ready=0 for the whole time the stage is held in reset.
    // ------------------------------------------------------------------------
    generate
        if (SKID != 0) begin : g_ready_skid
            // Registered ready: only a full skid register or a halt blocks
            // intake, so in_ready never depends on out_ready.
            assign in_ready = rst & ~skid_valid & ~halted;
        end else begin : g_ready_noskid
            // Single register: we can take a beat if main is empty or is
            // leaving on this same edge.
            assign in_ready = rst & (~main_valid | out_ready) & ~halted;
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign emit   = main_valid & out_ready;

    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign out_ctrl  = main_valid ? main_ctrl : '0;

    // ------------------------------------------------------------------------
    // Next-state logic.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        main_valid_d = main_valid;
        main_ctrl_d  = main_ctrl;
        main_data_d  = main_data;
        skid_valid_d = skid_valid;
        skid_ctrl_d  = skid_ctrl;
        skid_data_d  = skid_data;
        halted_d     = halted;

        if (flush) begin
            // Flush wins over everything: held beats and any concurrent
            // accept are dropped. Payload registers are left alone because
            // nothing downstream looks at them without a valid beat.
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
            halted_d     = 1'b0;
        end else begin
            if (emit && skid_valid) begin
                // Skid beat moves up. in_ready is low whenever skid is full,
                // so no accept can compete with this refill.
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl;
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
                skid_ctrl_d  = '0;
            end else if (accept && (!main_valid || emit)) begin
                // Main is empty or being vacated this edge.
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl;
                main_data_d  = in_data;
            end else if (accept) begin
                // Main is full and stalled: park the beat in skid. Only
                // reachable with SKID=1, since without a skid register
                // in_ready already requires main to be free or leaving.
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl;
                skid_data_d  = in_data;
            end else if (emit) begin
                // Beat leaves with nothing behind it: insert a bubble.
                main_valid_d = 1'b0;
                main_ctrl_d  = '0;
            end

            if (accept && in_ctrl[HALT_BIT]) begin
                halted_d = 1'b1;
            end
        end

        occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
    end

    // ------------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the payload registers are reset too, so that out_data
            // reads 0 after reset instead of leftover contents.
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            main_data  <= '0;
            halted     <= 1'b0;
            occupancy  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling
            // pre-edge values, independent of statement order.
            main_valid <= main_valid_d;
            main_ctrl  <= main_ctrl_d;
            main_data  <= main_data_d;
            halted     <= halted_d;
            occupancy  <= occupancy_d;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_regs
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    skid_valid <= 1'b0;
                    skid_ctrl  <= '0;
                    skid_data  <= '0;
                end else begin
                    skid_valid <= skid_valid_d;
                    skid_ctrl  <= skid_ctrl_d;
                    skid_data  <= skid_data_d;
                end
            end
        end else begin : g_no_skid
            // No skid storage in this build. The next-state values computed
            // above are ignored.
            assign skid_valid = 1'b0;
            assign skid_ctrl  = '0;
            assign skid_data  = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_hs.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_hs
//
// Drives a SKID=1 and a SKID=0 instance from the same input stimulus. Each
// instance is compared, cycle by cycle, against a reference model that treats
// the stage as a small FIFO of beats. A directed vector table covers
// backpressure, flush and halt. Hand-written sequences cover reset,
// streaming, the SKID=0 ready behaviour and a mid-operation reset. A
// randomized run follows.
// ----------------------------------------------------------------------------
module tb_pipe_stage_hs;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int HB = 0;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          ir1, ov1, h1;
    logic [CW-1:0] oc1;
    logic [DW-1:0] od1;
    logic [1:0]    occ1;

    logic          ir0, ov0, h0;
    logic [CW-1:0] oc0;
    logic [DW-1:0] od0;
    logic [1:0]    occ0;

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .HALT_BIT(HB)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1), .halted(h1)
    );

    pipe_stage_hs #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .HALT_BIT(HB)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0), .halted(h0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: per instance, an ordered list of up to 2 held beats
    // and a halt flag. Index 1 = SKID=1 instance, index 0 = SKID=0 instance.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
    } beat_t;

    beat_t m_buf [2][2];
    int    m_cnt [2];
    bit    m_halt[2];

    function automatic bit model_ready(input int k);
        if (rst !== 1'b1) return 1'b0;
        if (m_halt[k]) return 1'b0;
        if (k == 1) return (m_cnt[k] < 2);
        return (m_cnt[k] == 0) || (out_ready === 1'b1);
    endfunction

    task automatic model_check(input int k, input logic ir, input logic ov,
                               input logic [CW-1:0] oc, input logic [DW-1:0] od,
                               input logic [1:0] occ, input logic h);
        string p;
        p = (k == 1) ? "skid1" : "skid0";
        check({p, "_in_ready"},  64'(ir),  64'(model_ready(k)));
        check({p, "_out_valid"}, 64'(ov),  64'(m_cnt[k] > 0));
        check({p, "_out_ctrl"},  64'(oc),  (m_cnt[k] > 0) ? 64'(m_buf[k][0].ctrl) : 64'd0);
        if (m_cnt[k] > 0) check({p, "_out_data"}, 64'(od), 64'(m_buf[k][0].data));
        check({p, "_occupancy"}, 64'(occ), 64'(m_cnt[k]));
        check({p, "_halted"},    64'(h),   64'(m_halt[k]));
    endtask

    task automatic model_step(input int k);
        bit acc;
        bit emt;
        if (rst !== 1'b1) begin
            m_cnt[k]  = 0;
            m_halt[k] = 1'b0;
            return;
        end
        if (flush) begin
            m_cnt[k]  = 0;
            m_halt[k] = 1'b0;
            return;
        end
        acc = in_valid && model_ready(k);
        emt = (m_cnt[k] > 0) && out_ready;
        if (emt) begin
            m_buf[k][0] = m_buf[k][1];
            m_cnt[k]--;
        end
        if (acc) begin
            m_buf[k][m_cnt[k]] = {in_ctrl, in_data};
            m_cnt[k]++;
            if (in_ctrl[HB]) m_halt[k] = 1'b1;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then compare both
    // instances against the model once the inputs have settled.
    task automatic cyc(input logic fl, input logic iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input logic ordy);
        @(negedge clk);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        #1;
        model_check(1, ir1, ov1, oc1, od1, occ1, h1);
        model_check(0, ir0, ov0, oc0, od0, occ0, h0);
    endtask

    // Advance the model and the DUTs through the next rising edge.
    task automatic adv();
        model_step(1);
        model_step(0);
        @(posedge clk);
    endtask

    // ------------------------------------------------------------------------
    // Directed vectors for the SKID=1 instance: inputs of a cycle and the
    // outputs expected during that cycle (before its rising edge).
    // ------------------------------------------------------------------------
    typedef struct {
        logic          fl;
        logic          iv;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;
        logic          ordy;
        logic          ir;
        logic          ov;
        logic [CW-1:0] oc;
        logic [DW-1:0] od;
        logic [1:0]    occ;
        logic          h;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tbl[NVEC];

    initial begin
        // backpressure: A1 into main, A2 into skid, A3 refused, then drain
        tbl[0]  = '{1'b0, 1'b1, 4'h2, 16'h00A1, 1'b0,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 4'h2, 16'h00A2, 1'b0,  1'b1, 1'b1, 4'h2, 16'h00A1, 2'd1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 4'h2, 16'h00A3, 1'b0,  1'b0, 1'b1, 4'h2, 16'h00A1, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b0, 1'b1, 4'h2, 16'h00A1, 2'd2, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b1, 1'b1, 4'h2, 16'h00A2, 2'd1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b0,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        // flush with both registers full and B3 offered
        tbl[6]  = '{1'b0, 1'b1, 4'hE, 16'h00B1, 1'b0,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 4'hE, 16'h00B2, 1'b0,  1'b1, 1'b1, 4'hE, 16'h00B1, 2'd1, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 4'hE, 16'h00B3, 1'b0,  1'b0, 1'b1, 4'hE, 16'h00B1, 2'd2, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        // flush with concurrent emit of B4 and concurrent accept of B5
        tbl[10] = '{1'b0, 1'b1, 4'hE, 16'h00B4, 1'b1,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 4'hE, 16'h00B5, 1'b1,  1'b1, 1'b1, 4'hE, 16'h00B4, 2'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        // halt: C0 carries the halt marker, C1 must never be taken
        tbl[13] = '{1'b0, 1'b1, 4'h1, 16'h00C0, 1'b0,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 4'h0, 16'h00C1, 1'b0,  1'b0, 1'b1, 4'h1, 16'h00C0, 2'd1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 4'h0, 16'h00C1, 1'b1,  1'b0, 1'b1, 4'h1, 16'h00C0, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 4'h0, 16'h00C1, 1'b1,  1'b0, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b0, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b1,  1'b1, 1'b0, 4'h0, 16'h0000, 2'd0, 1'b0};
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k]  = 0;
            m_halt[k] = 1'b0;
        end

        // ---------------- reset / idle ----------------
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 4'h2, 16'h1234, 1'b1);
            check("reset_out_data", 64'(od1), 64'd0);
            check("reset_in_ready", 64'(ir1), 64'd0);
            adv();
        end
        #2 rst = 1'b1;
        cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b1);
        check("ready_after_reset", 64'(ir1), 64'd1);
        adv();

        // ---------------- streaming ----------------
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 4'h2, 16'(16'h10 + i), 1'b1);
            if (i > 0) begin
                check("stream_valid", 64'(ov1), 64'd1);
                check("stream_data",  64'(od1), 64'(16'h10 + i - 1));
            end
            adv();
        end
        cyc(1'b0, 1'b0, 4'h0, 16'h0000, 1'b1);
        check("stream_last", 64'(od1), 64'h17);
        adv();

        // ---------------- directed vector table ----------------
        cyc(1'b1, 1'b0, 4'h0, 16'h0000, 1'b1);
        adv();
        for (int i = 0; i < NVEC; i++) begin
            cyc(tbl[i].fl, tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy);
            check($sformatf("vec%0d_in_ready", i),  64'(ir1),  64'(tbl[i].ir));
            check($sformatf("vec%0d_out_valid", i), 64'(ov1),  64'(tbl[i].ov));
            check($sformatf("vec%0d_out_ctrl", i),  64'(oc1),  64'(tbl[i].oc));
            if (tbl[i].ov) check($sformatf("vec%0d_out_data", i), 64'(od1), 64'(tbl[i].od));
            check($sformatf("vec%0d_occupancy", i), 64'(occ1), 64'(tbl[i].occ));
            check($sformatf("vec%0d_halted", i),    64'(h1),   64'(tbl[i].h));
            adv();
        end

        // ---------------- SKID=0: out_ready toggling ----------------
        cyc(1'b1, 1'b0, 4'h0, 16'h0000, 1'b1);
        adv();
        for (int i = 0; i < 8; i++) begin
            logic ordy;
            ordy = (i % 2 == 0);
            cyc(1'b0, 1'b1, 4'h2, 16'(16'h40 + i), ordy);
            if (ov0) check("skid0_ready_follows", 64'(ir0), 64'(ordy));
            check("skid0_occ_max1", 64'(occ0 <= 2'd1), 64'd1);
            adv();
        end

        // ---------------- reset mid-operation ----------------
        cyc(1'b1, 1'b0, 4'h0, 16'h0000, 1'b0);
        adv();
        cyc(1'b0, 1'b1, 4'h2, 16'h00D1, 1'b0);
        adv();
        cyc(1'b0, 1'b1, 4'h2, 16'h00D2, 1'b0);
        adv();
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_valid1", 64'(ov1),  64'd0);
        check("async_rst_occ1",   64'(occ1), 64'd0);
        check("async_rst_data1",  64'(od1),  64'd0);
        check("async_rst_ready1", 64'(ir1),  64'd0);
        check("async_rst_valid0", 64'(ov0),  64'd0);
        check("async_rst_occ0",   64'(occ0), 64'd0);
        m_cnt[0] = 0; m_cnt[1] = 0; m_halt[0] = 1'b0; m_halt[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1, 4'h2, 16'h00D3, 1'b1);
            adv();
        end
        #2 rst = 1'b1;

        // ---------------- randomized run ----------------
        for (int i = 0; i < 1500; i++) begin
            logic          fl, iv, ordy;
            logic [CW-1:0] ic;
            logic [DW-1:0] id;
            fl   = ($urandom_range(0, 31) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            ic   = CW'($urandom);
            ic[HB] = ($urandom_range(0, 15) == 0);
            id   = DW'($urandom);
            cyc(fl, iv, ic, id, ordy);
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
